ax301_segment_scanner: RTL

Time-multiplexed driver for the AX301 board's common-select 7-segment display bank, generalised to any digit count, scan rate and polarity. Takes a packed hex value with per-digit decimal-point and blank masks from a CPU-side register interface and scans one digit at a time onto the segment and select pins. Writes are double-buffered and committed only at frame boundaries so the display never tears. Per-digit blanking gaps suppress ghosting. Sits between the memory-mapped peripheral bus glue and the board pins.

---
 rtl/ax301_segment_scanner.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ax301_segment_scanner.sv
// Time-multiplexed 7-segment scanner: double-buffered hex/dp/blank content,
// committed only at frame wrap, with a blanking gap at the start of every digit slot.
module ax301_segment_scanner #(
  parameter int NUM_DIGITS     = 6,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_value,
  input  logic [NUM_DIGITS-1:0]   wr_dp,
  input  logic [NUM_DIGITS-1:0]   wr_blank,
  output logic [7:0]              segment,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_sh_value, r_com_value;
  logic [NUM_DIGITS-1:0]   r_sh_dp, r_com_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank, r_com_blank;
  logic                    r_pending;
  logic [7:0]              r_segment;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic                    r_frame_done;

  logic                    w_cnt_last;
  logic                    w_idx_last;
  logic                    w_wrap;
  logic                    w_in_blank;
  logic                    w_active;
  logic [7:0]              w_dig_seg [NUM_DIGITS];
  logic [7:0]              w_raw_seg;
  logic [NUM_DIGITS-1:0]   w_sel_hot;
  logic [7:0]              w_seg_drive;
  logic [NUM_DIGITS-1:0]   w_sel_drive;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
    endcase
  endfunction

  assign w_cnt_last = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_wrap     = en & w_cnt_last & w_idx_last;

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_in_blank = 1'b0;
    end else begin : g_blank
      assign w_in_blank = (r_cnt < CNT_W'(BLANK_CYCLES));
    end
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign w_dig_seg[gi] = {r_com_dp[gi], hex7(r_com_value[4*gi +: 4])};
    end
  endgenerate

  assign w_raw_seg   = w_dig_seg[r_idx];
  assign w_sel_hot   = NUM_DIGITS'(1'b1) << r_idx;
  assign w_active    = en & ~w_in_blank & ~r_com_blank[r_idx];
  assign w_seg_drive = (SEG_ACTIVE_LOW != 0) ? ~w_raw_seg : w_raw_seg;
  assign w_sel_drive = (SEL_ACTIVE_LOW != 0) ? ~w_sel_hot : w_sel_hot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (!en) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_cnt_last) begin
      r_cnt <= '0;
      r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // While stopped the committed copy follows the shadow so re-enabling shows fresh data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_value  <= '0;
      r_sh_dp     <= '0;
      r_sh_blank  <= '0;
      r_com_value <= '0;
      r_com_dp    <= '0;
      r_com_blank <= '0;
      r_pending   <= 1'b0;
    end else if (!en) begin
      r_pending <= 1'b0;
      if (wr_en) begin
        r_sh_value  <= wr_value;
        r_sh_dp     <= wr_dp;
        r_sh_blank  <= wr_blank;
        r_com_value <= wr_value;
        r_com_dp    <= wr_dp;
        r_com_blank <= wr_blank;
      end else begin
        r_com_value <= r_sh_value;
        r_com_dp    <= r_sh_dp;
        r_com_blank <= r_sh_blank;
      end
    end else if (w_wrap) begin
      r_pending <= 1'b0;
      if (wr_en) begin
        r_sh_value  <= wr_value;
        r_sh_dp     <= wr_dp;
        r_sh_blank  <= wr_blank;
        r_com_value <= wr_value;
        r_com_dp    <= wr_dp;
        r_com_blank <= wr_blank;
      end else if (r_pending) begin
        r_com_value <= r_sh_value;
        r_com_dp    <= r_sh_dp;
        r_com_blank <= r_sh_blank;
      end
    end else if (wr_en) begin
      r_sh_value <= wr_value;
      r_sh_dp    <= wr_dp;
      r_sh_blank <= wr_blank;
      r_pending  <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_segment    <= SEG_OFF;
      r_sel        <= SEL_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_segment    <= w_active ? w_seg_drive : SEG_OFF;
      r_sel        <= w_active ? w_sel_drive : SEL_OFF;
      r_frame_done <= w_wrap;
    end
  end

  assign segment    = r_segment;
  assign sel        = r_sel;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule
